// File: rtl/video_frame_gen_if.sv
// Pixel-memory read port plus video timing outputs of the frame generator.
// Latency: signal bundle only; no backpressure, the memory must answer one cycle after rd_en.
interface video_frame_gen_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 24
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  video_vsync;
    logic                  video_hsync;
    logic                  video_de;
    logic [DATA_WIDTH-1:0] video_data;
    logic                  frame_done;
    logic [15:0]           frame_cnt;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output video_vsync, video_hsync, video_de, video_data, frame_done, frame_cnt
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  video_vsync, video_hsync, video_de, video_data, frame_done, frame_cnt
    );
endinterface

// File: rtl/video_frame_gen.sv
// Raster timing generator that fetches pixels from memory and emits sync/de/data.
// Latency: rd_en 1 clk after counters, video 3 clks, frame_done 4 clks; no backpressure.
module video_frame_gen #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_FRONT    = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_FRONT    = 10,
    parameter int DATA_WIDTH = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    video_frame_gen_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(IMG_HDISP*IMG_VDISP);
    localparam int H_TOTAL    = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
    localparam int V_TOTAL    = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
    localparam int HW         = $clog2(H_TOTAL + 1);
    localparam int VW         = $clog2(V_TOTAL + 1);
    localparam int H_ACT_BEG  = H_SYNC + H_BACK;
    localparam int V_ACT_BEG  = V_SYNC + V_BACK;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_B    = HW'(H_ACT_BEG);
    localparam logic [HW-1:0] H_ACT_E    = HW'(H_ACT_BEG + IMG_HDISP);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_B    = VW'(V_ACT_BEG);
    localparam logic [VW-1:0] V_ACT_E    = VW'(V_ACT_BEG + IMG_VDISP);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   h_cnt, h_nxt;
    logic [VW-1:0]   v_cnt, v_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Leaving RUN is only allowed at the last clock of a frame, so frames are never cut short.
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        case (state)
            IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    if (v_cnt == V_LAST) begin
                        v_nxt = '0;
                        if (!en) state_nxt = IDLE;
                    end else begin
                        v_nxt = v_cnt + VW'(1);
                    end
                end else begin
                    h_nxt = h_cnt + HW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        endcase
    end

    logic                  run;
    logic                  hs0, vs0, de0, fe0;
    logic [ADDR_WIDTH-1:0] addr0;

    always_comb begin
        run   = (state == RUN);
        hs0   = run && (h_cnt < H_SYNC_END);
        vs0   = run && (v_cnt < V_SYNC_END);
        de0   = run && (h_cnt >= H_ACT_B) && (h_cnt < H_ACT_E)
                    && (v_cnt >= V_ACT_B) && (v_cnt < V_ACT_E);
        fe0   = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
        addr0 = '0;
        if (de0)
            addr0 = ADDR_WIDTH'((int'(v_cnt) - V_ACT_BEG) * IMG_HDISP + (int'(h_cnt) - H_ACT_BEG));
    end

    // Stages free-run regardless of state so an ending frame drains out after RUN->IDLE.
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  hs1, vs1, fe1;
    logic                  de2, hs2, vs2, fe2;
    logic                  hs3, vs3, de3, fe3;
    logic [DATA_WIDTH-1:0] data3;
    logic                  frame_done_q;
    logic [15:0]           frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            hs1          <= 1'b0;
            vs1          <= 1'b0;
            fe1          <= 1'b0;
            de2          <= 1'b0;
            hs2          <= 1'b0;
            vs2          <= 1'b0;
            fe2          <= 1'b0;
            hs3          <= 1'b0;
            vs3          <= 1'b0;
            de3          <= 1'b0;
            fe3          <= 1'b0;
            data3        <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            rd_en_q      <= de0;
            rd_addr_q    <= addr0;
            hs1          <= hs0;
            vs1          <= vs0;
            fe1          <= fe0;
            de2          <= rd_en_q;
            hs2          <= hs1;
            vs2          <= vs1;
            fe2          <= fe1;
            hs3          <= hs2;
            vs3          <= vs2;
            de3          <= de2;
            fe3          <= fe2;
            data3        <= de2 ? bus.rd_data : '0;
            frame_done_q <= fe3;
            if (fe3) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.video_hsync = hs3;
    assign bus.video_vsync = vs3;
    assign bus.video_de    = de3;
    assign bus.video_data  = data3;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_video_frame_gen.sv
// Bench for video_frame_gen on a 4x2 image with unit sync/porch widths (7x5 = 35 clocks/frame).
// A frame-position model predicts every output each cycle; directed steps cover en drop, reset and wrap.
module tb_video_frame_gen;
    localparam int HD = 4;
    localparam int VD = 2;
    localparam int HSY = 1, HBP = 1, HFP = 1;
    localparam int VSY = 1, VBP = 1, VFP = 1;
    localparam int HT = HSY + HBP + HD + HFP;
    localparam int VT = VSY + VBP + VD + VFP;
    localparam int FT = HT * VT;
    localparam int AW = $clog2(HD * VD);
    localparam int DW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    video_frame_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    video_frame_gen #(
        .IMG_HDISP(HD), .IMG_VDISP(VD),
        .H_SYNC(HSY), .H_BACK(HBP), .H_FRONT(HFP),
        .V_SYNC(VSY), .V_BACK(VBP), .V_FRONT(VFP),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Memory: addr+0x100 one cycle after a strobe, noise otherwise.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= DW'(32'h100 + 32'(bus.rd_addr));
        else           bus.rd_data <= DW'($urandom);
    end

    // Model: cur is the frame position the next edge will act on (-1 = idle);
    // hist[0] is the position acted on at the latest edge, hist[k] k edges earlier.
    int          cur = -1;
    int          hist[4];
    logic [15:0] m_cnt = 16'd0;

    function automatic bit in_act(int p);
        int h, v;
        if (p < 0) return 1'b0;
        h = p % HT;
        v = p / HT;
        return (h >= HSY + HBP) && (h < HSY + HBP + HD) && (v >= VSY + VBP) && (v < VSY + VBP + VD);
    endfunction

    function automatic int lin_addr(int p);
        return ((p / HT) - (VSY + VBP)) * HD + ((p % HT) - (HSY + HBP));
    endfunction

    function automatic bit hs_of(int p);
        return (p >= 0) && ((p % HT) < HSY);
    endfunction

    function automatic bit vs_of(int p);
        return (p >= 0) && ((p / HT) < VSY);
    endfunction

    task automatic model_reset();
        cur = -1;
        for (int i = 0; i < 4; i++) hist[i] = -1;
        m_cnt = 16'd0;
    endtask

    task automatic model_edge(input bit en_s);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = cur;
        if (cur < 0 || cur == FT - 1) cur = en_s ? 0 : -1;
        else                          cur = cur + 1;
        if (hist[3] == FT - 1) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_en",       32'(bus.rd_en),       32'(in_act(hist[0])));
        chk("rd_addr",     32'(bus.rd_addr),     in_act(hist[0]) ? 32'(lin_addr(hist[0])) : 32'd0);
        chk("video_hsync", 32'(bus.video_hsync), 32'(hs_of(hist[2])));
        chk("video_vsync", 32'(bus.video_vsync), 32'(vs_of(hist[2])));
        chk("video_de",    32'(bus.video_de),    32'(in_act(hist[2])));
        chk("video_data",  32'(bus.video_data),  in_act(hist[2]) ? 32'h100 + 32'(lin_addr(hist[2])) : 32'd0);
        chk("frame_done",  32'(bus.frame_done),  32'(hist[3] == FT - 1));
        chk("frame_cnt",   32'(bus.frame_cnt),   32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else        model_edge(en);
        check_all();
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 4 * FT && cur != p; i++) tick();
        chk("reach_pos", 32'(dut.h_cnt) + 32'(HT) * 32'(dut.v_cnt), 32'(p));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd_en"},  32'(bus.rd_en),       32'd0);
        chk({tag, "_addr"},   32'(bus.rd_addr),     32'd0);
        chk({tag, "_hsync"},  32'(bus.video_hsync), 32'd0);
        chk({tag, "_vsync"},  32'(bus.video_vsync), 32'd0);
        chk({tag, "_de"},     32'(bus.video_de),    32'd0);
        chk({tag, "_data"},   32'(bus.video_data),  32'd0);
        chk({tag, "_done"},   32'(bus.frame_done),  32'd0);
    endtask

    int          last_done;
    int          nframes;
    int          ndone;
    int          first_addr;
    int          first_data;
    logic [31:0] pix_q[$];

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        repeat (2) tick();

        // en held from reset release: three frames, 35 clocks apart, pixels in raster order
        rst_n = 1'b1;
        en    = 1'b1;
        last_done = -1;
        nframes   = 0;
        for (int i = 0; i < 3 * FT + 12; i++) begin
            tick();
            if (bus.video_de && nframes == 0) pix_q.push_back(32'(bus.video_data));
            if (bus.frame_done) begin
                nframes++;
                if (last_done >= 0) chk("done_period", 32'(cyc - last_done), 32'(FT));
                chk("frame_cnt_seq", 32'(bus.frame_cnt), 32'(nframes));
                last_done = cyc;
            end
        end
        chk("frames_seen", 32'(nframes), 32'd3);
        chk("pix_count", 32'(pix_q.size()), 32'(HD * VD));
        for (int i = 0; i < pix_q.size(); i++) chk("pix_order", pix_q[i], 32'h100 + 32'(i));

        // en dropped mid-frame: frame completes, then the block goes quiet
        wait_pos(10);
        en    = 1'b0;
        ndone = 0;
        for (int i = 0; i < FT + 10; i++) begin
            tick();
            if (bus.frame_done) ndone++;
        end
        chk("drop_done_cnt", 32'(ndone), 32'd1);
        chk_quiet("idle");
        chk("idle_h_cnt", 32'(dut.h_cnt), 32'd0);
        chk("idle_v_cnt", 32'(dut.v_cnt), 32'd0);

        // random run-request toggling
        en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if ($urandom_range(0, 24) == 0) en = ~en;
        end

        // asynchronous reset mid-frame, then a fresh frame from address 0
        en = 1'b1;
        wait_pos(20);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_quiet("mid_reset");
        chk("mid_reset_cnt", 32'(bus.frame_cnt), 32'd0);
        repeat (3) tick();
        rst_n      = 1'b1;
        first_addr = -1;
        first_data = -1;
        for (int i = 0; i < 2 * FT && first_data < 0; i++) begin
            tick();
            if (bus.rd_en && first_addr < 0) first_addr = int'(bus.rd_addr);
            if (bus.video_de && first_data < 0) first_data = int'(bus.video_data);
        end
        chk("post_rst_addr", 32'(first_addr), 32'd0);
        chk("post_rst_data", 32'(first_data), 32'h100);

        // frame counter wrap
        wait_pos(5);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        ndone = 0;
        for (int i = 0; i < 2 * FT && ndone == 0; i++) begin
            tick();
            if (bus.frame_done) ndone++;
        end
        chk("wrap_done", 32'(ndone), 32'd1);
        chk("wrap_cnt", 32'(bus.frame_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
